tree_walker: RTL and testbench

//  Decision-tree traversal engine. It sits directly upstream of the 16-feature tree node ROM:
//  - drives the ROM address and consumes the 120-bit node words (1-cycle registered read);
//  - compares a stored fp64 feature against the node's fp64 threshold and follows the chosen child until a leaf;
//  - returns the leaf class with a done pulse.

---
 rtl/tree_node_pkg.sv | 45 ++++
 rtl/fp64_le_cmp.sv | 24 ++
 rtl/tree_walker.sv | 161 ++++++++++++++++
 tb/tb_tree_walker.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tree_node_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tree_node_pkg
// Purpose  : Node-word field layout, widths and helper functions shared by the
//            decision-tree traversal engine.
// Revision : 1.0  initial release
// ============================================================================
package tree_node_pkg;

    localparam int c_node_w  = 120;
    localparam int c_fp_w    = 64;
    localparam int c_idx_w   = 4;
    localparam int c_class_w = 4;
    localparam int c_child_w = 12;

    // Node word field positions
    localparam int c_id_msb    = 107;
    localparam int c_id_lsb    = 96;
    localparam int c_idx_msb   = 95;
    localparam int c_idx_lsb   = 92;
    localparam int c_thr_msb   = 91;
    localparam int c_thr_lsb   = 28;
    localparam int c_left_msb  = 27;
    localparam int c_left_lsb  = 16;
    localparam int c_right_msb = 15;
    localparam int c_right_lsb = 4;
    localparam int c_class_msb = 3;
    localparam int c_class_lsb = 0;

    typedef logic [c_child_w-1:0] child_t;
    typedef logic [c_class_w-1:0] class_t;
    typedef logic [c_idx_w-1:0]   fidx_t;

    // A node with no children is a leaf (the root is never a child, so 0 means "none")
    function automatic logic node_is_leaf(input logic [c_node_w-1:0] node);
        return (node[c_left_msb:c_left_lsb] == '0) && (node[c_right_msb:c_right_lsb] == '0);
    endfunction

    // Monotonic unsigned key: ordering of keys matches numeric ordering of doubles
    function automatic logic [c_fp_w-1:0] fp64_key(input logic [c_fp_w-1:0] x);
        return x[c_fp_w-1] ? ~x : (x ^ {1'b1, {(c_fp_w-1){1'b0}}});
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp64_le_cmp.sv
`default_nettype none
// ============================================================================
// Module   : fp64_le_cmp
// Purpose  : Combinational IEEE-754 double a <= b, treating -0.0 == +0.0.
// Revision : 1.0  initial release
// ============================================================================
module fp64_le_cmp
    import tree_node_pkg::*;
(
    input  logic [c_fp_w-1:0] i_a,
    input  logic [c_fp_w-1:0] i_b,
    output logic              o_le
);

    logic w_both_zero;
    logic w_key_le;

    // Signed zeros map to adjacent but distinct keys, so they are forced equal here
    assign w_both_zero = (i_a[c_fp_w-2:0] == '0) && (i_b[c_fp_w-2:0] == '0);
    assign w_key_le    = (fp64_key(i_a) <= fp64_key(i_b));
    assign o_le        = w_both_zero | w_key_le;

endmodule
`default_nettype wire

// File: rtl/tree_walker.sv
`default_nettype none
// ============================================================================
// Module   : tree_walker
// Purpose  : Decision-tree traversal engine. Fetches node words from a
//            1-cycle registered ROM, compares a stored fp64 feature against the
//            node threshold, follows the chosen child to a leaf and reports the
//            leaf class (or a fault) with a one-cycle done pulse.
// Revision : 1.0  initial release
// ============================================================================
module tree_walker
    import tree_node_pkg::*;
#(
    parameter int NODE_WIDTH   = 120,
    parameter int ADDR_WIDTH   = 10,
    parameter int ROM_DEPTH    = 512,
    parameter int NUM_FEATURES = 16,
    parameter int MAX_DEPTH    = 32,
    parameter int ROOT_ADDR    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  feat_wr_en,
    input  logic [c_idx_w-1:0]    feat_wr_idx,
    input  logic [c_fp_w-1:0]     feat_wr_data,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [c_class_w-1:0]  class_out,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [NODE_WIDTH-1:0] rom_data
);

    localparam int c_depth_w = $clog2(MAX_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_root = ADDR_WIDTH'(ROOT_ADDR);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_fetch = 2'd1;
    localparam logic [1:0] c_st_eval  = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [c_depth_w-1:0]  r_depth;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    class_t                r_class;
    logic [c_fp_w-1:0]     r_feat [NUM_FEATURES];

    fidx_t             w_idx;
    logic [c_fp_w-1:0] w_thr;
    child_t            w_left;
    child_t            w_right;
    child_t            w_child;
    logic [c_fp_w-1:0] w_feat;
    logic              w_leaf;
    logic              w_idx_ok;
    logic              w_child_ok;
    logic              w_depth_max;
    logic              w_fault;
    logic              w_go_left;

    // Node word decode (valid while in EVAL)
    assign w_idx   = rom_data[c_idx_msb:c_idx_lsb];
    assign w_thr   = rom_data[c_thr_msb:c_thr_lsb];
    assign w_left  = rom_data[c_left_msb:c_left_lsb];
    assign w_right = rom_data[c_right_msb:c_right_lsb];
    assign w_leaf  = node_is_leaf(rom_data[c_node_w-1:0]);

    assign w_idx_ok = (32'(w_idx) < 32'(NUM_FEATURES));
    assign w_feat   = w_idx_ok ? r_feat[w_idx] : '0;

    fp64_le_cmp u_cmp (
        .i_a  (w_feat),
        .i_b  (w_thr),
        .o_le (w_go_left)
    );

    assign w_child     = w_go_left ? w_left : w_right;
    assign w_child_ok  = ((w_child >> ADDR_WIDTH) == '0) && (32'(w_child) < 32'(ROM_DEPTH));
    assign w_depth_max = (r_depth == c_depth_w'(MAX_DEPTH - 1));
    assign w_fault     = !w_idx_ok || !w_child_ok || w_depth_max;

    assign busy      = r_busy;
    assign done      = r_done;
    assign class_out = r_class;
    assign err       = r_err;
    assign rom_addr  = r_ptr;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_st_idle;
        else     r_state <= w_state_nxt;
    end

    // Next-state: fetch/evaluate alternate until a leaf or a fault ends the walk
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (start) w_state_nxt = c_st_fetch;
            c_st_fetch: w_state_nxt = c_st_eval;
            c_st_eval:  w_state_nxt = (w_leaf || w_fault) ? c_st_idle : c_st_fetch;
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    // Pointer, depth and result registers; pointer parks on the root when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr   <= c_root;
            r_depth <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_class <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_ptr   <= c_root;
                        r_depth <= '0;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                c_st_eval: begin
                    if (w_leaf) begin
                        r_class <= rom_data[c_class_msb:c_class_lsb];
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_ptr   <= c_root;
                    end else if (w_fault) begin
                        r_class <= '0;
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_ptr   <= c_root;
                    end else begin
                        r_ptr   <= w_child[ADDR_WIDTH-1:0];
                        r_depth <= r_depth + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Feature register file: writable only while idle so a walk sees stable features
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_FEATURES; i++) r_feat[i] <= '0;
        end else if (feat_wr_en && (r_state == c_st_idle) &&
                     (32'(feat_wr_idx) < 32'(NUM_FEATURES))) begin
            r_feat[feat_wr_idx] <= feat_wr_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tree_walker.sv
`default_nettype none
// ============================================================================
// Module   : tb_tree_walker
// Purpose  : Self-checking bench for tree_walker: directed boundary walks plus
//            randomized trees checked against a behavioural traversal model.
// Revision : 1.0  initial release
// ============================================================================
module tb_tree_walker;

    localparam int c_nfeat = 12;

    logic         clk = 1'b0;
    logic         rst;
    logic         feat_wr_en;
    logic [3:0]   feat_wr_idx;
    logic [63:0]  feat_wr_data;
    logic         start;
    logic         busy;
    logic         done;
    logic [3:0]   class_out;
    logic         err;
    logic [9:0]   rom_addr;
    logic [119:0] rom_data;

    logic [119:0] rom [1024];
    logic [63:0]  mfeat [16];

    int n_chk  = 0;
    int n_pass = 0;

    tree_walker #(.NUM_FEATURES(c_nfeat)) dut (
        .clk          (clk),
        .rst          (rst),
        .feat_wr_en   (feat_wr_en),
        .feat_wr_idx  (feat_wr_idx),
        .feat_wr_data (feat_wr_data),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .class_out    (class_out),
        .err          (err),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data)
    );

    always #5 clk = ~clk;

    // Registered ROM model
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [119:0] mk_node(input logic [3:0] idx, input logic [63:0] thr,
                                             input logic [11:0] l, input logic [11:0] r,
                                             input logic [3:0] cls);
        logic [119:0] n;
        n = '0;
        n[95:92] = idx;
        n[91:28] = thr;
        n[27:16] = l;
        n[15:4]  = r;
        n[3:0]   = cls;
        return n;
    endfunction

    // Reference traversal on real numbers (real compare treats -0.0 == +0.0)
    function automatic void ref_walk(output logic [3:0] cls, output bit e, output int vis);
        int unsigned ptr = 0;
        cls = '0; e = 1'b0; vis = 0;
        for (int d = 0; d < 32; d++) begin
            logic [119:0] node;
            logic [11:0]  l, r, ch;
            int unsigned  idx;
            node = rom[ptr];
            l = node[27:16];
            r = node[15:4];
            vis = d + 1;
            if (l == 0 && r == 0) begin
                cls = node[3:0];
                return;
            end
            idx = node[95:92];
            if (idx >= c_nfeat) begin e = 1'b1; return; end
            ch = ($bitstoreal(mfeat[idx]) <= $bitstoreal(node[91:28])) ? l : r;
            if (ch >= 512 || d == 31) begin e = 1'b1; return; end
            ptr = ch;
        end
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 1024; i++) rom[i] = '0;
    endtask

    task automatic write_feat(input logic [3:0] idx, input logic [63:0] data);
        @(negedge clk);
        feat_wr_en = 1'b1; feat_wr_idx = idx; feat_wr_data = data;
        @(posedge clk); #1;
        feat_wr_en = 1'b0;
        if (idx < c_nfeat) mfeat[idx] = data;
    endtask

    task automatic run_walk(input string tag, input logic [3:0] ecls, input bit eerr,
                            input int evis, input bit hold, input bit wrbusy,
                            input bit co_wr, input logic [63:0] co_data);
        int cyc = 0;
        bit seen = 1'b0;
        @(negedge clk);
        start = 1'b1;
        if (co_wr) begin
            feat_wr_en = 1'b1; feat_wr_idx = 4'd0; feat_wr_data = co_data;
            mfeat[0] = co_data;
        end
        @(posedge clk); #1;
        feat_wr_en = 1'b0;
        if (!hold) start = 1'b0;
        chk({tag, ":busy"}, 64'(busy), 64'd1);
        while (!seen && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (wrbusy && cyc == 1) begin
                feat_wr_en = 1'b1; feat_wr_idx = 4'd0; feat_wr_data = 64'h7FE0_0000_0000_0000;
            end else begin
                feat_wr_en = 1'b0;
            end
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        chk({tag, ":seen"}, 64'(seen), 64'd1);
        chk({tag, ":lat"}, 64'(cyc), 64'(2 * evis));
        chk({tag, ":class"}, 64'(class_out), 64'(ecls));
        chk({tag, ":err"}, 64'(err), 64'(eerr));
        chk({tag, ":busy_end"}, 64'(busy), 64'd0);
        @(posedge clk); #1;
        chk({tag, ":pulse"}, {62'd0, done, busy}, 64'd0);
        chk({tag, ":hold"}, {59'd0, err, class_out}, {59'd0, eerr, ecls});
        chk({tag, ":addr"}, 64'(rom_addr), 64'd0);
    endtask

    task automatic model_walk(input string tag, input bit hold, input bit wrbusy);
        logic [3:0] c; bit e; int v;
        ref_walk(c, e, v);
        run_walk(tag, c, e, v, hold, wrbusy, 1'b0, 64'd0);
    endtask

    function automatic logic [63:0] pick_val();
        logic [63:0] tbl [8];
        logic [63:0] x;
        tbl[0] = 64'h0000_0000_0000_0000; tbl[1] = 64'h8000_0000_0000_0000;
        tbl[2] = 64'h4000_0000_0000_0000; tbl[3] = 64'h4000_0000_0000_0001;
        tbl[4] = 64'hBFE0_0000_0000_0000; tbl[5] = 64'hBFF0_0000_0000_0000;
        tbl[6] = 64'hBFD0_0000_0000_0000; tbl[7] = 64'h3FF0_0000_0000_0000;
        if ($urandom_range(0, 1) == 0) return tbl[$urandom_range(0, 7)];
        x = {$urandom, $urandom};
        if (x[62:52] == 11'h7FF) x[62] = 1'b0;
        return x;
    endfunction

    initial begin
        logic [3:0] c; bit e; int v;
        rst = 1'b1; start = 1'b0; feat_wr_en = 1'b0; feat_wr_idx = '0; feat_wr_data = '0;
        for (int i = 0; i < 16; i++) mfeat[i] = '0;
        clear_rom();
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        chk("rst_outs", {59'd0, busy, done, err, class_out[1:0]}, 64'd0);
        chk("rst_class", 64'(class_out), 64'd0);
        chk("rst_addr", 64'(rom_addr), 64'd0);

        // Root leaf
        rom[0] = mk_node(0, 0, 0, 0, 4'd1);
        run_walk("root_leaf", 4'd1, 1'b0, 1, 0, 0, 0, 0);

        // One-level tree on feature 0 with threshold 2.0
        rom[0] = mk_node(0, 64'h4000_0000_0000_0000, 12'd1, 12'd2, 0);
        rom[1] = mk_node(0, 0, 0, 0, 4'd0);
        rom[2] = mk_node(0, 0, 0, 0, 4'd1);
        write_feat(0, 64'h4000_0000_0000_0000);
        run_walk("eq_left", 4'd0, 1'b0, 2, 0, 0, 0, 0);
        write_feat(0, 64'h4000_0000_0000_0001);
        run_walk("ulp_right", 4'd1, 1'b0, 2, 0, 0, 0, 0);
        rom[0] = mk_node(0, 64'h0, 12'd1, 12'd2, 0);
        write_feat(0, 64'h8000_0000_0000_0000);
        run_walk("negz_le_posz", 4'd0, 1'b0, 2, 0, 0, 0, 0);
        rom[0] = mk_node(0, 64'h8000_0000_0000_0000, 12'd1, 12'd2, 0);
        write_feat(0, 64'h0);
        run_walk("posz_le_negz", 4'd0, 1'b0, 2, 0, 0, 0, 0);

        // Negative thresholds
        rom[0] = mk_node(0, 64'hBFE0_0000_0000_0000, 12'd1, 12'd2, 0);
        write_feat(0, 64'hBFF0_0000_0000_0000);
        run_walk("neg_left", 4'd0, 1'b0, 2, 0, 0, 0, 0);
        write_feat(0, 64'hBFD0_0000_0000_0000);
        run_walk("neg_right", 4'd1, 1'b0, 2, 0, 0, 0, 0);

        // Self-loop runs out of depth
        clear_rom();
        rom[0] = mk_node(0, 0, 12'h005, 12'h005, 0);
        rom[5] = mk_node(0, 0, 12'h005, 12'h005, 0);
        run_walk("depth_fault", 4'd0, 1'b1, 32, 0, 0, 0, 0);

        // Feature index faults and the last legal index
        rom[0] = mk_node(4'hF, 0, 12'd1, 12'd2, 0);
        run_walk("idx15_fault", 4'd0, 1'b1, 1, 0, 0, 0, 0);
        rom[0] = mk_node(4'd12, 0, 12'd1, 12'd2, 0);
        run_walk("idx12_fault", 4'd0, 1'b1, 1, 0, 0, 0, 0);
        rom[1] = mk_node(0, 0, 0, 0, 4'd6);
        rom[0] = mk_node(4'd11, 0, 12'd1, 12'd2, 0);
        run_walk("idx11_ok", 4'd6, 1'b0, 2, 0, 0, 0, 0);

        // Child address range
        write_feat(0, 64'h0);
        rom[0] = mk_node(0, 64'h4000_0000_0000_0000, 12'h200, 12'd2, 0);
        run_walk("child512_fault", 4'd0, 1'b1, 1, 0, 0, 0, 0);
        rom[0] = mk_node(0, 64'h4000_0000_0000_0000, 12'h401, 12'd2, 0);
        run_walk("child_hi_fault", 4'd0, 1'b1, 1, 0, 0, 0, 0);
        rom[0] = mk_node(0, 64'h4000_0000_0000_0000, 12'h1FF, 12'd2, 0);
        rom[12'h1FF] = mk_node(0, 0, 0, 0, 4'd7);
        run_walk("child511_ok", 4'd7, 1'b0, 2, 0, 0, 0, 0);

        // Hazards on the 2.0 tree
        clear_rom();
        rom[0] = mk_node(0, 64'h4000_0000_0000_0000, 12'd1, 12'd2, 0);
        rom[1] = mk_node(0, 0, 0, 0, 4'd3);
        rom[2] = mk_node(0, 0, 0, 0, 4'd9);
        write_feat(0, 64'h0);
        run_walk("hold_start", 4'd3, 1'b0, 2, 1, 0, 0, 0);
        run_walk("wr_busy", 4'd3, 1'b0, 2, 0, 1, 0, 0);
        run_walk("after_wr_busy", 4'd3, 1'b0, 2, 0, 0, 0, 0);
        run_walk("wr_with_start", 4'd9, 1'b0, 2, 0, 0, 1, 64'h4008_0000_0000_0000);

        // Reset in the first EVAL cycle, then a clean walk with cleared features
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        for (int i = 0; i < 16; i++) mfeat[i] = '0;
        chk("midrst_state", {61'd0, busy, done, err}, 64'd0);
        begin
            int nd = 0;
            repeat (4) begin
                @(posedge clk); #1;
                if (done) nd++;
            end
            chk("midrst_nodone", 64'(nd), 64'd0);
        end
        run_walk("after_rst", 4'd3, 1'b0, 2, 0, 0, 0, 0);

        // Randomized trees against the reference model
        for (int t = 0; t < 40; t++) begin
            clear_rom();
            for (int a = 0; a < 64; a++) begin
                if (a != 0 && $urandom_range(0, 3) == 0) begin
                    rom[a] = mk_node(0, 0, 0, 0, 4'($urandom_range(0, 15)));
                end else begin
                    logic [11:0] l, r;
                    logic [3:0]  idx;
                    l = 12'($urandom_range(a + 1, a + 8));
                    r = 12'($urandom_range(a + 1, a + 8));
                    if ($urandom_range(0, 29) == 0) l = 12'($urandom_range(512, 4095));
                    idx = ($urandom_range(0, 24) == 0) ? 4'($urandom_range(12, 15))
                                                       : 4'($urandom_range(0, 11));
                    rom[a] = mk_node(idx, pick_val(), l, r, 4'($urandom_range(0, 15)));
                end
            end
            for (int k = 0; k < 4; k++) write_feat(4'($urandom_range(0, 11)), pick_val());
            ref_walk(c, e, v);
            run_walk($sformatf("rand%0d", t), c, e, v,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
